// File: rtl/match_reporter.sv
// Captures the first matching candidate from the hash-lane array and reports it
// once over an 8N1 UART as uppercase hex followed by CR LF.
module match_reporter #(
  parameter int LANES        = 10,
  parameter int LANE_BITS    = 4,
  parameter int COUNT_W      = 29,
  parameter int PIPE_LATENCY = 64,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [LANES-1:0]               found,
  input  logic [COUNT_W-1:0]             count,
  output logic [COUNT_W+LANE_BITS-1:0]   result,
  output logic                           result_valid,
  output logic                           multi_hit,
  output logic                           overrun,
  output logic                           busy,
  output logic                           tx
);

  // state | meaning
  // IDLE  | line idle (tx high), waiting for a capture
  // START | start bit (tx low) of the current byte
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (tx high); then next byte or back to IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int RES_W      = COUNT_W + LANE_BITS;
  localparam int HEX_DIGITS = (RES_W + 3) / 4;
  localparam int PAD_W      = 4 * HEX_DIGITS;
  localparam int NBYTES     = HEX_DIGITS + 2;
  localparam int BYTE_W     = $clog2(NBYTES);
  localparam int TMR_W      = $clog2(CLKS_PER_BIT);
  localparam int WARM_W     = $clog2(PIPE_LATENCY + 1);

  localparam logic [TMR_W-1:0] BIT_LOAD = TMR_W'(CLKS_PER_BIT - 1);

  logic [COUNT_W-1:0]   delay_line [PIPE_LATENCY];
  logic [COUNT_W-1:0]   tail;
  logic [WARM_W-1:0]    warm_cnt;
  logic                 warm_done;
  logic [LANE_BITS-1:0] hit_idx;
  logic                 any_hit;
  logic                 multi;
  logic                 capture;

  logic [1:0]           state;
  logic [TMR_W-1:0]     bit_tmr;
  logic [2:0]           bit_idx;
  logic [BYTE_W-1:0]    byte_idx;
  logic [PAD_W-1:0]     padded;
  logic [3:0]           nib;
  logic [7:0]           tx_byte;

  // The tail is the counter value that produced this cycle's found flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) delay_line[i] <= '0;
    end else begin
      delay_line[0] <= count;
      for (int i = 1; i < PIPE_LATENCY; i++) delay_line[i] <= delay_line[i-1];
    end
  end

  assign tail = delay_line[PIPE_LATENCY-1];

  always_ff @(posedge CLK) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign warm_done = (warm_cnt == WARM_W'(PIPE_LATENCY));

  always_comb begin
    hit_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (found[i]) hit_idx = LANE_BITS'(i);
    end
  end

  assign any_hit = |found;
  assign multi   = |(found & (found - LANES'(1)));
  assign capture = any_hit && warm_done && !result_valid;

  always_ff @(posedge CLK) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      multi_hit    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (capture) begin
        result       <= {tail, hit_idx};
        result_valid <= 1'b1;
        multi_hit    <= multi;
      end
      if (any_hit && (result_valid || busy)) overrun <= 1'b1;
    end
  end

  assign padded = PAD_W'(result);

  always_comb begin
    nib     = 4'h0;
    tx_byte = 8'h0A;
    if (byte_idx < BYTE_W'(HEX_DIGITS)) begin
      nib     = 4'(padded >> (4 * (HEX_DIGITS - 1 - int'(byte_idx))));
      tx_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (byte_idx == BYTE_W'(HEX_DIGITS)) begin
      tx_byte = 8'h0D;
    end
  end

  // tx is registered and updated on the same edge the state changes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (capture) begin
            state    <= START;
            bit_tmr  <= BIT_LOAD;
            byte_idx <= '0;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_tmr == '0) begin
            state   <= DATA;
            bit_tmr <= BIT_LOAD;
            bit_idx <= '0;
            tx      <= tx_byte[0];
          end else begin
            bit_tmr <= bit_tmr - TMR_W'(1);
          end
        end
        DATA: begin
          if (bit_tmr == '0) begin
            bit_tmr <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            bit_tmr <= bit_tmr - TMR_W'(1);
          end
        end
        default: begin
          if (bit_tmr == '0) begin
            if (byte_idx == BYTE_W'(NBYTES - 1)) begin
              state <= IDLE;
              tx    <= 1'b1;
            end else begin
              state    <= START;
              bit_tmr  <= BIT_LOAD;
              byte_idx <= byte_idx + BYTE_W'(1);
              tx       <= 1'b0;
            end
          end else begin
            bit_tmr <= bit_tmr - TMR_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_match_reporter.sv
// Scoreboard bench for match_reporter: stimulus queues expected captures and
// UART bytes; monitors pop and compare when the DUT presents them.
module tb_match_reporter;
  localparam int CPB = 4;
  localparam int LAT = 8;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  found = '0;
  logic [28:0] count = '0;
  logic [32:0] result;
  logic        result_valid, multi_hit, overrun, busy, tx;

  match_reporter #(
    .LANES(10), .LANE_BITS(4), .COUNT_W(29),
    .PIPE_LATENCY(LAT), .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK(CLK), .reset(reset), .found(found), .count(count),
    .result(result), .result_valid(result_valid), .multi_hit(multi_hit),
    .overrun(overrun), .busy(busy), .tx(tx)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic        ramp_en = 1'b0;
  logic [32:0] exp_res_q[$];
  logic        exp_mh_q[$];
  logic [7:0]  exp_byte_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (ramp_en) count = count + 29'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1; found = '0; ramp_en = 1'b0; count = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_count(input logic [28:0] target);
    int n;
    n = 0;
    while (count != target && n < 1000) begin
      tick();
      n++;
    end
    check("wait_count_bound", {63'd0, count == target}, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < 2000);
    check("frame_end_bound", {63'd0, busy}, 64'd0);
  endtask

  task automatic push_frame(input string s, input logic crlf);
    for (int i = 0; i < s.len(); i++) exp_byte_q.push_back(s[i]);
    if (crlf) begin
      exp_byte_q.push_back(8'h0D);
      exp_byte_q.push_back(8'h0A);
    end
  endtask

  // capture monitor
  logic prev_rv = 1'b0;
  always @(negedge CLK) begin
    if (!reset && result_valid && !prev_rv) begin
      if (exp_res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_capture actual=%0h required=none", result);
      end else begin
        check("capture_result", 64'(result), 64'(exp_res_q.pop_front()));
        check("capture_multi_hit", 64'(multi_hit), 64'(exp_mh_q.pop_front()));
      end
    end
    prev_rv = result_valid;
  end

  // UART decoder, sampling mid-bit
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  always @(negedge CLK) begin
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + 1 && rx_cnt <= 8 * CPB + 1 && (rx_cnt - 1) % CPB == 0) begin
        rx_byte[(rx_cnt - 1) / CPB - 1] = tx;
      end else if (rx_cnt == 9 * CPB + 1) begin
        check("uart_stop_bit", 64'(tx), 64'd1);
        if (exp_byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_byte);
        end else begin
          check("uart_byte", 64'(rx_byte), 64'(exp_byte_q.pop_front()));
        end
        rx_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // reset values, then idle line
    reset = 1'b1; found = '0; count = '0;
    repeat (3) tick();
    @(negedge CLK);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_multi_hit", 64'(multi_hit), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx", 64'(tx), 64'd1);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (tx !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    check("idle_line_bad_cycles", 64'(bad), 64'd0);

    // single hit on lane 3, with an overrun pulse on lane 9 mid-frame
    do_reset();
    ramp_en = 1'b1;
    wait_count(29'h20);
    found = 10'b0000001000;
    exp_res_q.push_back(33'h183); exp_mh_q.push_back(1'b0);
    push_frame("000000183", 1'b1);
    tick();
    found = '0;
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (!busy) break;
      n++;
      found = (n == 100) ? 10'b1000000000 : 10'b0;
    end
    found = '0;
    check("busy_cycles", 64'(n), 64'd440);
    check("overrun_set", 64'(overrun), 64'd1);
    check("result_held", 64'(result), 64'h183);
    check("multi_hit_single", 64'(multi_hit), 64'd0);
    check("tx_idle_after_frame", 64'(tx), 64'd1);

    // stalled counter, two lanes hit together
    do_reset();
    ramp_en = 1'b1;
    wait_count(29'h30);
    ramp_en = 1'b0;
    repeat (12) tick();
    found = 10'b0000100100;
    exp_res_q.push_back(33'h302); exp_mh_q.push_back(1'b1);
    push_frame("000000302", 1'b1);
    tick();
    found = '0;
    repeat (7) tick();
    ramp_en = 1'b1;
    wait_idle();
    check("stall_result", 64'(result), 64'h302);
    check("stall_multi_hit", 64'(multi_hit), 64'd1);
    check("stall_no_overrun", 64'(overrun), 64'd0);

    // hit during warm-up is ignored
    do_reset();
    ramp_en = 1'b1;
    repeat (4) tick();
    found = 10'b0000000001;
    tick();
    found = '0;
    repeat (20) tick();
    @(negedge CLK);
    check("warmup_result_valid", 64'(result_valid), 64'd0);
    check("warmup_tx", 64'(tx), 64'd1);
    check("warmup_busy", 64'(busy), 64'd0);
    check("warmup_overrun", 64'(overrun), 64'd0);

    // reset in the DATA phase of the fifth byte, then a clean capture
    do_reset();
    ramp_en = 1'b1;
    wait_count(29'h20);
    found = 10'b0000000010;
    exp_res_q.push_back(33'h181); exp_mh_q.push_back(1'b0);
    push_frame("0000", 1'b0);
    tick();
    found = '0;
    repeat (179) tick();
    reset = 1'b1;
    tick();
    @(negedge CLK);
    check("midreset_tx", 64'(tx), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_result_valid", 64'(result_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    reset = 1'b0;
    count = '0;
    wait_count(29'h20);
    found = 10'b0000001000;
    exp_res_q.push_back(33'h183); exp_mh_q.push_back(1'b0);
    push_frame("000000183", 1'b1);
    tick();
    found = '0;
    wait_idle();
    check("recapture_result", 64'(result), 64'h183);
    check("recapture_overrun", 64'(overrun), 64'd0);

    repeat (5) tick();
    check("leftover_captures", 64'(exp_res_q.size()), 64'd0);
    check("leftover_bytes", 64'(exp_byte_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
